muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 SHALL have parameter ALU_OP, default 5, meaning width of the ALU control code.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  execute stage presents an operation.
REQ-006 SHALL have port req_op  input  ALU_OP  ALU control code (ALU_MUL..ALU_DIVU codes 5'b00110..5'b01101).
REQ-007 SHALL have ports req_a, req_b  input  WIDTH  rs1 and rs2 operands.
REQ-008 SHALL have port req_rd  input  5  destination register tag.
REQ-009 SHALL have port flush  input  1  pipeline flush; aborts any operation in flight.
REQ-010 SHALL have port req_ready  output  1  block can accept an operation.
REQ-011 SHALL have port stall  output  1  freezes the pipeline front end.
REQ-012 SHALL have ports rsp_valid (1), rsp_data (WIDTH), rsp_rd (5), all outputs: one-cycle writeback result.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; req_ready = 1 only in IDLE.
REQ-014 SHALL accept an operation when state IDLE, req_valid = 1, flush = 0 and req_op in ALU_MUL..ALU_DIVU; operands, op, rd latched at that edge, IDLE->BUSY.
REQ-015 SHALL ignore req_valid with any other req_op: no state change, no stall.
REQ-016 SHALL drive stall combinationally = (IDLE and acceptance condition true) or state == BUSY; stall = 0 in DONE.
REQ-017 SHALL perform one radix-2 iteration per cycle in BUSY using a 6-bit counter 0..WIDTH-1; at the edge where counter = WIDTH-1, BUSY->DONE.
REQ-018 SHALL give latency: accept at edge k, rsp_valid high for exactly the cycle after edge k+WIDTH, DONE->IDLE at edge k+WIDTH+1.
REQ-019 SHALL compute multiply by shift-add on magnitudes (MUL, MULH: both signed; MULHSU: a signed, b unsigned; MULHU: unsigned), negating the 2*WIDTH product when operand signs differ.
REQ-020 SHALL return low WIDTH bits for MUL, high WIDTH bits for MULH/MULHSU/MULHU.
REQ-021 SHALL compute divide by restoring shift-subtract on magnitudes; quotient sign = sign(a) xor sign(b), remainder sign = sign(a), for DIV/REM; DIVU/REMU unsigned.
REQ-022 SHALL return, for divisor 0: quotient all-ones (DIV, DIVU), remainder = req_a (REM, REMU).
REQ-023 SHALL return, for DIV/REM with a = 0x80000000 and b = 0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-024 SHALL, on flush in BUSY or DONE, go to IDLE at the next edge with rsp_valid = 0 in the following cycle; flush in IDLE blocks acceptance.
REQ-025 SHALL hold rsp_data and rsp_rd registered; their value is meaningful only while rsp_valid = 1.

Reset
REQ-026 SHALL, on rst_n = 0 at any time including mid-operation, immediately enter IDLE, clear counter, and force rsp_valid = 0, rsp_data = 0, rsp_rd = 0; req_ready = 1, stall = 0 after reset.
REQ-027 SHALL resume normal acceptance at the first rising edge after rst_n returns high.

Configuration
REQ-028 SHALL support macro MULDIV_EARLY_OUT_EN; when defined, divisor-zero and signed-overflow cases (REQ-022, REQ-023) bypass BUSY: IDLE->DONE at accept edge, rsp_valid in the next cycle (latency 1).
REQ-029 SHALL, without MULDIV_EARLY_OUT_EN, run all operations through the full WIDTH-cycle BUSY sequence; result values identical in both builds.

Verification
REQ-030 SHALL cover: MUL a=7, b=6 -> rsp_valid exactly 33 cycles after accept, rsp_data = 42, rsp_rd echoes req_rd, stall high 33 cycles.
REQ-031 SHALL cover: a=b=0xFFFFFFFF: MULH -> 0x00000000, MULHU -> 0xFFFFFFFE, MULHSU -> 0xFFFFFFFF, MUL -> 0x00000001.
REQ-032 SHALL cover: DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-033 SHALL cover: DIVU a=5, b=0 -> 0xFFFFFFFF; REMU -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; latency 33 without, 1 with MULDIV_EARLY_OUT_EN.
REQ-034 SHALL cover: flush at BUSY cycle 10 -> no rsp_valid, req_ready = 1 next cycle; new MUL 3*3 then returns 9 after 33 cycles.
REQ-035 SHALL cover: rst_n low at BUSY cycle 20 -> outputs zero immediately, req_ready = 1, no rsp_valid after release; non-muldiv op (ALU_ADD) with req_valid -> stall = 0, state stays IDLE.

Source files
------------

// File: rtl/muldiv_seq.sv
// ============================================================================
// muldiv_seq : sequential radix-2 multiply/divide unit (shift-add / restoring)
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow
// complete in one cycle instead of the full iteration sequence.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module muldiv_seq #(
   parameter int WIDTH  = 32,
   parameter int ALU_OP = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic [ALU_OP-1:0] req_op,
   input  logic [WIDTH-1:0]  req_a,
   input  logic [WIDTH-1:0]  req_b,
   input  logic [4:0]        req_rd,
   input  logic              flush,
   output logic              req_ready,
   output logic              stall,
   output logic              rsp_valid,
   output logic [WIDTH-1:0]  rsp_data,
   output logic [4:0]        rsp_rd
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [ALU_OP-1:0] c_MUL    = ALU_OP'(6);
   localparam logic [ALU_OP-1:0] c_MULH   = ALU_OP'(7);
   localparam logic [ALU_OP-1:0] c_MULHSU = ALU_OP'(8);
   localparam logic [ALU_OP-1:0] c_MULHU  = ALU_OP'(9);
   localparam logic [ALU_OP-1:0] c_DIV    = ALU_OP'(10);
   localparam logic [ALU_OP-1:0] c_REM    = ALU_OP'(11);
   localparam logic [ALU_OP-1:0] c_REMU   = ALU_OP'(12);
   localparam logic [ALU_OP-1:0] c_DIVU   = ALU_OP'(13);
   localparam logic [5:0]        c_LAST   = 6'(WIDTH - 1);

   logic [1:0]         r_state;
   logic [5:0]         r_cnt;
   logic [ALU_OP-1:0]  r_op;
   logic [4:0]         r_rd;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opnd;
   logic               r_negq;
   logic               r_nega;
   logic               r_divz;

   logic               w_is_md;
   logic               w_is_div;
   logic               w_accept;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_ma;
   logic [WIDTH-1:0]   w_mb;
   logic               w_divz;
   logic [WIDTH:0]     w_msum;
   logic [WIDTH:0]     w_dhi;
   logic               w_dge;
   logic [WIDTH-1:0]   w_dtrial;
   logic [2*WIDTH-1:0] w_acc_next;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_result;

   assign w_is_md  = (req_op >= c_MUL) && (req_op <= c_DIVU);
   assign w_is_div = (req_op >= c_DIV);
   assign w_accept = (r_state == IDLE) && req_valid && !flush && w_is_md;
   assign req_ready = (r_state == IDLE);
   assign stall     = w_accept || (r_state == BUSY);

   // Operand a is signed for MUL/MULH/MULHSU/DIV/REM; b only for MUL/MULH/DIV/REM.
   assign w_a_neg = req_a[WIDTH-1] && (req_op == c_MUL || req_op == c_MULH ||
                    req_op == c_MULHSU || req_op == c_DIV || req_op == c_REM);
   assign w_b_neg = req_b[WIDTH-1] && (req_op == c_MUL || req_op == c_MULH ||
                    req_op == c_DIV || req_op == c_REM);
   assign w_ma    = w_a_neg ? -req_a : req_a;
   assign w_mb    = w_b_neg ? -req_b : req_b;
   assign w_divz  = w_is_div && (req_b == '0);

`ifdef MULDIV_EARLY_OUT_EN
   logic             w_ovf;
   logic [WIDTH-1:0] w_early_data;
   assign w_ovf = (req_op == c_DIV || req_op == c_REM) &&
                  (req_a == {1'b1, {(WIDTH-1){1'b0}}}) && (req_b == '1);
   assign w_early_data = w_divz ? ((req_op == c_DIV || req_op == c_DIVU) ? '1 : req_a)
                                : ((req_op == c_DIV) ? req_a : '0);
`endif

   // Multiply: acc = {partial product, remaining multiplier bits}.
   assign w_msum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
   assign w_dhi    = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_dge    = (w_dhi >= {1'b0, r_opnd});
   assign w_dtrial = w_dhi[WIDTH-1:0] - r_opnd;

   always_comb begin
      w_acc_next = {w_msum, r_acc[WIDTH-1:1]};
      if (r_op >= c_DIV) begin
         w_acc_next = w_dge ? {w_dtrial, r_acc[WIDTH-2:0], 1'b1}
                            : {r_acc[2*WIDTH-2:0], 1'b0};
      end
   end

   assign w_prod = r_negq ? -w_acc_next : w_acc_next;
   assign w_quo  = w_acc_next[WIDTH-1:0];
   assign w_rem  = w_acc_next[2*WIDTH-1:WIDTH];

   always_comb begin
      w_result = w_prod[2*WIDTH-1:WIDTH];
      case (r_op)
         c_MUL:   w_result = w_prod[WIDTH-1:0];
         c_DIV:   w_result = r_divz ? '1 : (r_negq ? -w_quo : w_quo);
         c_DIVU:  w_result = r_divz ? '1 : w_quo;
         c_REM:   w_result = r_nega ? -w_rem : w_rem;
         c_REMU:  w_result = w_rem;
         default: w_result = w_prod[2*WIDTH-1:WIDTH];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_op      <= '0;
         r_rd      <= '0;
         r_acc     <= '0;
         r_opnd    <= '0;
         r_negq    <= 1'b0;
         r_nega    <= 1'b0;
         r_divz    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_rd    <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op   <= req_op;
                  r_rd   <= req_rd;
                  r_cnt  <= '0;
                  r_opnd <= w_is_div ? w_mb : w_ma;
                  r_acc  <= {{WIDTH{1'b0}}, (w_is_div ? w_ma : w_mb)};
                  r_negq <= w_a_neg ^ w_b_neg;
                  r_nega <= w_a_neg;
                  r_divz <= w_divz;
`ifdef MULDIV_EARLY_OUT_EN
                  if (w_divz || w_ovf) begin
                     r_state   <= DONE;
                     rsp_valid <= 1'b1;
                     rsp_data  <= w_early_data;
                     rsp_rd    <= req_rd;
                  end else begin
                     r_state <= BUSY;
                  end
`else
                  r_state <= BUSY;
`endif
               end
            end
            BUSY: begin
               if (flush) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_acc <= w_acc_next;
                  if (r_cnt == c_LAST) begin
                     r_state   <= DONE;
                     r_cnt     <= '0;
                     rsp_valid <= 1'b1;
                     rsp_data  <= w_result;
                     rsp_rd    <= r_rd;
                  end else begin
                     r_cnt <= r_cnt + 6'd1;
                  end
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
